// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: initiator side of the system PLL dynamic-reconfiguration
// port. Accepts one divider/duty/phase request at a time, range-checks it,
// drives the new settings, pulses pll_rst and waits for a filtered lock.
// Also runs the power-on reset/lock sequence without issuing a response.
module pll_dyn_cfg_ctrl #(
    parameter int unsigned DEF_IDIV     = 2,
    parameter int unsigned DEF_FDIV     = 32,
    parameter int unsigned DEF_ODIV     = 100,
    parameter int unsigned DEF_DUTY     = 100,
    parameter int unsigned DEF_PHASE    = 16,
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [9:0]  cfg_idiv,
    input  logic [9:0]  cfg_fdiv,
    input  logic [9:0]  cfg_odiv0,
    input  logic [9:0]  cfg_odiv1,
    input  logic [9:0]  cfg_odiv2,
    input  logic [9:0]  cfg_duty0,
    input  logic [9:0]  cfg_duty1,
    input  logic [9:0]  cfg_duty2,
    input  logic [12:0] cfg_phase0,
    input  logic [12:0] cfg_phase1,
    input  logic [12:0] cfg_phase2,
    output logic        resp_valid,
    output logic [1:0]  resp_code,
    output logic [9:0]  dyn_idiv,
    output logic [9:0]  dyn_fdiv,
    output logic [9:0]  dyn_odiv0,
    output logic [9:0]  dyn_odiv1,
    output logic [9:0]  dyn_odiv2,
    output logic [9:0]  dyn_duty0,
    output logic [9:0]  dyn_duty1,
    output logic [9:0]  dyn_duty2,
    output logic [12:0] dyn_phase0,
    output logic [12:0] dyn_phase1,
    output logic [12:0] dyn_phase2,
    output logic        pll_rst,
    input  logic        pll_lock,
    output logic        locked,
    output logic        lock_lost
);

    localparam int unsigned RW = $clog2(RST_CYCLES + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [SW-1:0] STAB_DONE = SW'(LOCK_STABLE);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);

    localparam logic [1:0] RESP_OK  = 2'b00;
    localparam logic [1:0] RESP_REJ = 2'b01;
    localparam logic [1:0] RESP_TO  = 2'b10;

    typedef enum logic [2:0] {
        BOOT_RST,
        IDLE,
        CHECK,
        APPLY_RST,
        WAIT_LOCK,
        RESP
    } state_t;

    typedef struct packed {
        logic [9:0]       idiv;
        logic [9:0]       fdiv;
        logic [2:0][9:0]  odiv;
        logic [2:0][9:0]  duty;
        logic [2:0][12:0] phase;
    } pll_cfg_t;

    localparam pll_cfg_t DEF_CFG = '{
        idiv:  10'(DEF_IDIV),
        fdiv:  10'(DEF_FDIV),
        odiv:  {3{10'(DEF_ODIV)}},
        duty:  {3{10'(DEF_DUTY)}},
        phase: {3{13'(DEF_PHASE)}}
    };

    state_t          state, state_nxt;
    pll_cfg_t        cfg_in, req_q, dyn_q;
    logic [RW-1:0]   rst_cnt, rst_cnt_d;
    logic [SW-1:0]   stab_cnt, stab_cnt_d;
    logic [TW-1:0]   to_cnt, to_cnt_d;
    logic            boot, boot_d;
    logic            pll_rst_d, locked_d, lock_lost_d;
    logic [1:0]      resp_code_d;
    logic            load_dyn;
    logic            hs, req_bad;
    logic            rst_done, stab_done, to_done;

    assign hs        = (state == IDLE) && cfg_valid && cfg_ready;
    assign rst_done  = (rst_cnt == RST_LAST);
    assign stab_done = (stab_cnt == STAB_DONE);
    assign to_done   = (to_cnt == TO_LAST);

    // Gather the request ports into one record for capture.
    always_comb begin
        cfg_in       = '0;
        cfg_in.idiv  = cfg_idiv;
        cfg_in.fdiv  = cfg_fdiv;
        cfg_in.odiv  = {cfg_odiv2, cfg_odiv1, cfg_odiv0};
        cfg_in.duty  = {cfg_duty2, cfg_duty1, cfg_duty0};
        cfg_in.phase = {cfg_phase2, cfg_phase1, cfg_phase0};
    end

    // Range check of the captured request; widths chosen so 2*odiv and 8*odiv never truncate.
    always_comb begin
        req_bad = (req_q.idiv == '0) || (req_q.fdiv == '0);
        for (int i = 0; i < 3; i++) begin
            if ((req_q.odiv[i] == '0) || (req_q.duty[i] == '0) ||
                ({1'b0, req_q.duty[i]} >= {req_q.odiv[i], 1'b0}) ||
                (req_q.phase[i] >= {req_q.odiv[i], 3'b000}))
                req_bad = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= BOOT_RST;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT_RST:  if (rst_done) state_nxt = WAIT_LOCK;
            IDLE:      if (hs) state_nxt = CHECK;
            CHECK:     state_nxt = req_bad ? RESP : APPLY_RST;
            APPLY_RST: if (rst_done) state_nxt = WAIT_LOCK;
            WAIT_LOCK: if (stab_done || to_done) state_nxt = boot ? IDLE : RESP;
            RESP:      state_nxt = IDLE;
            default:   state_nxt = BOOT_RST;
        endcase
    end

    // Output/datapath decode: next values for every registered output and counter.
    // Counters default to zero so each timed state starts counting from 0.
    always_comb begin
        rst_cnt_d   = '0;
        stab_cnt_d  = '0;
        to_cnt_d    = '0;
        pll_rst_d   = pll_rst;
        locked_d    = locked;
        lock_lost_d = 1'b0;
        resp_code_d = resp_code;
        boot_d      = boot;
        load_dyn    = 1'b0;
        case (state)
            BOOT_RST, APPLY_RST: begin
                if (rst_done) pll_rst_d = 1'b0;
                else          rst_cnt_d = rst_cnt + 1'b1;
            end
            IDLE: begin
                // A single low sample while locked counts as lock loss; no retry.
                if (locked && !pll_lock) begin
                    locked_d    = 1'b0;
                    lock_lost_d = 1'b1;
                end
            end
            CHECK: begin
                if (req_bad) begin
                    resp_code_d = RESP_REJ;
                end else begin
                    load_dyn  = 1'b1;
                    pll_rst_d = 1'b1;
                    locked_d  = 1'b0;
                end
            end
            WAIT_LOCK: begin
                // Stable lock wins over timeout when both land on the same cycle.
                if (stab_done) begin
                    locked_d = 1'b1;
                    boot_d   = 1'b0;
                    if (!boot) resp_code_d = RESP_OK;
                end else if (to_done) begin
                    boot_d = 1'b0;
                    if (!boot) resp_code_d = RESP_TO;
                end else begin
                    to_cnt_d   = to_cnt + 1'b1;
                    stab_cnt_d = pll_lock ? stab_cnt + 1'b1 : '0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs, counters and request/setting storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_cnt    <= '0;
            stab_cnt   <= '0;
            to_cnt     <= '0;
            boot       <= 1'b1;
            pll_rst    <= 1'b1;
            locked     <= 1'b0;
            lock_lost  <= 1'b0;
            resp_code  <= RESP_OK;
            resp_valid <= 1'b0;
            cfg_ready  <= 1'b0;
            req_q      <= '0;
            dyn_q      <= DEF_CFG;
        end else begin
            rst_cnt    <= rst_cnt_d;
            stab_cnt   <= stab_cnt_d;
            to_cnt     <= to_cnt_d;
            boot       <= boot_d;
            pll_rst    <= pll_rst_d;
            locked     <= locked_d;
            lock_lost  <= lock_lost_d;
            resp_code  <= resp_code_d;
            resp_valid <= (state_nxt == RESP);
            cfg_ready  <= (state_nxt == IDLE);
            if (hs)       req_q <= cfg_in;
            if (load_dyn) dyn_q <= req_q;
        end
    end

    assign dyn_idiv   = dyn_q.idiv;
    assign dyn_fdiv   = dyn_q.fdiv;
    assign dyn_odiv0  = dyn_q.odiv[0];
    assign dyn_odiv1  = dyn_q.odiv[1];
    assign dyn_odiv2  = dyn_q.odiv[2];
    assign dyn_duty0  = dyn_q.duty[0];
    assign dyn_duty1  = dyn_q.duty[1];
    assign dyn_duty2  = dyn_q.duty[2];
    assign dyn_phase0 = dyn_q.phase[0];
    assign dyn_phase1 = dyn_q.phase[1];
    assign dyn_phase2 = dyn_q.phase[2];

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Directed bench for pll_dyn_cfg_ctrl (RST_CYCLES=16, LOCK_STABLE=64, LOCK_TIMEOUT=200).
// Timeline comments use T = edge where the handshake is sampled; outputs are
// read 1 time unit after each rising edge.
module tb_pll_dyn_cfg_ctrl;

    logic        clk_tb;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [9:0]  cfg_idiv, cfg_fdiv;
    logic [9:0]  cfg_odiv0, cfg_odiv1, cfg_odiv2;
    logic [9:0]  cfg_duty0, cfg_duty1, cfg_duty2;
    logic [12:0] cfg_phase0, cfg_phase1, cfg_phase2;
    logic        resp_valid;
    logic [1:0]  resp_code;
    logic [9:0]  dyn_idiv, dyn_fdiv;
    logic [9:0]  dyn_odiv0, dyn_odiv1, dyn_odiv2;
    logic [9:0]  dyn_duty0, dyn_duty1, dyn_duty2;
    logic [12:0] dyn_phase0, dyn_phase1, dyn_phase2;
    logic        pll_rst;
    logic        pll_lock;
    logic        locked;
    logic        lock_lost;

    int n_tests = 0;
    int n_fail  = 0;

    pll_dyn_cfg_ctrl #(
        .RST_CYCLES   (16),
        .LOCK_STABLE  (64),
        .LOCK_TIMEOUT (200)
    ) dut (
        .clk        (clk_tb),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_idiv   (cfg_idiv),
        .cfg_fdiv   (cfg_fdiv),
        .cfg_odiv0  (cfg_odiv0),
        .cfg_odiv1  (cfg_odiv1),
        .cfg_odiv2  (cfg_odiv2),
        .cfg_duty0  (cfg_duty0),
        .cfg_duty1  (cfg_duty1),
        .cfg_duty2  (cfg_duty2),
        .cfg_phase0 (cfg_phase0),
        .cfg_phase1 (cfg_phase1),
        .cfg_phase2 (cfg_phase2),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .dyn_idiv   (dyn_idiv),
        .dyn_fdiv   (dyn_fdiv),
        .dyn_odiv0  (dyn_odiv0),
        .dyn_odiv1  (dyn_odiv1),
        .dyn_odiv2  (dyn_odiv2),
        .dyn_duty0  (dyn_duty0),
        .dyn_duty1  (dyn_duty1),
        .dyn_duty2  (dyn_duty2),
        .dyn_phase0 (dyn_phase0),
        .dyn_phase1 (dyn_phase1),
        .dyn_phase2 (dyn_phase2),
        .pll_rst    (pll_rst),
        .pll_lock   (pll_lock),
        .locked     (locked),
        .lock_lost  (lock_lost)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_tb);
            #1;
        end
    endtask

    task automatic cfg_defaults();
        cfg_idiv   = 10'd2;
        cfg_fdiv   = 10'd32;
        cfg_odiv0  = 10'd100;
        cfg_odiv1  = 10'd100;
        cfg_odiv2  = 10'd100;
        cfg_duty0  = 10'd100;
        cfg_duty1  = 10'd100;
        cfg_duty2  = 10'd100;
        cfg_phase0 = 13'd16;
        cfg_phase1 = 13'd16;
        cfg_phase2 = 13'd16;
    endtask

    // One-cycle handshake: valid is presented for the edge T only.
    task automatic handshake();
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string pfx);
        chk({pfx, "_pll_rst"},   pll_rst,    1);
        chk({pfx, "_cfg_ready"}, cfg_ready,  0);
        chk({pfx, "_resp_vld"},  resp_valid, 0);
        chk({pfx, "_resp_code"}, resp_code,  0);
        chk({pfx, "_locked"},    locked,     0);
        chk({pfx, "_lock_lost"}, lock_lost,  0);
        chk({pfx, "_idiv"},      dyn_idiv,   2);
        chk({pfx, "_fdiv"},      dyn_fdiv,   32);
        chk({pfx, "_odiv0"},     dyn_odiv0,  100);
        chk({pfx, "_duty2"},     dyn_duty2,  100);
        chk({pfx, "_phase1"},    dyn_phase1, 16);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        pll_lock  = 1'b0;
        cfg_defaults();

        // ---- Reset then boot lock ----
        tick(3);
        chk_reset_state("rst");
        rst_n = 1'b1;                     // last reset edge was E0
        tick(15);
        chk("boot_rst_hi_16", pll_rst, 1);
        tick(1);
        chk("boot_rst_fall", pll_rst, 0);
        chk("boot_not_ready", cfg_ready, 0);
        tick(5);
        pll_lock = 1'b1;                  // 5 cycles after pll_rst falls
        tick(64);
        chk("boot_not_locked_yet", locked, 0);
        tick(1);
        chk("boot_locked", locked, 1);
        chk("boot_ready", cfg_ready, 1);
        chk("boot_no_resp", resp_valid, 0);
        chk("boot_resp_code", resp_code, 0);

        // ---- Valid reconfig: odiv/duty = 200, plus ignored request during WAIT_LOCK ----
        cfg_odiv0 = 10'd200; cfg_odiv1 = 10'd200; cfg_odiv2 = 10'd200;
        cfg_duty0 = 10'd200; cfg_duty1 = 10'd200; cfg_duty2 = 10'd200;
        handshake();                      // edge T
        chk("rc_ready_fall", cfg_ready, 0);
        chk("rc_dyn_unchanged_check", dyn_odiv0, 100);
        tick(1);                          // T+1
        chk("rc_odiv0", dyn_odiv0, 200);
        chk("rc_odiv2", dyn_odiv2, 200);
        chk("rc_duty1", dyn_duty1, 200);
        chk("rc_pll_rst_rise", pll_rst, 1);
        chk("rc_locked_clr", locked, 0);
        tick(15);                         // T+16
        chk("rc_pll_rst_hi", pll_rst, 1);
        tick(1);                          // T+17
        chk("rc_pll_rst_fall", pll_rst, 0);
        tick(3);                          // T+20: garbage request that must be ignored
        cfg_odiv1 = 10'd0;
        cfg_valid = 1'b1;
        tick(10);                         // T+30
        cfg_valid = 1'b0;
        cfg_odiv1 = 10'd200;
        tick(51);                         // T+81
        chk("rc_no_resp_early", resp_valid, 0);
        tick(1);                          // T+82
        chk("rc_resp_valid", resp_valid, 1);
        chk("rc_resp_code", resp_code, 0);
        chk("rc_locked", locked, 1);
        tick(1);
        chk("rc_resp_1cyc", resp_valid, 0);
        chk("rc_ready_back", cfg_ready, 1);
        tick(3);
        chk("ign_no_extra_resp", resp_valid, 0);
        chk("ign_dyn_odiv1", dyn_odiv1, 200);
        chk("ign_ready", cfg_ready, 1);

        // ---- Rejection A: duty0=200, odiv0=100 (2*odiv boundary) ----
        cfg_defaults();
        cfg_duty0 = 10'd200;
        handshake();
        tick(1);                          // T+1
        chk("rejA_resp_valid", resp_valid, 1);
        chk("rejA_code", resp_code, 1);
        chk("rejA_pll_rst", pll_rst, 0);
        chk("rejA_dyn_odiv0", dyn_odiv0, 200);
        chk("rejA_dyn_duty0", dyn_duty0, 200);
        chk("rejA_locked", locked, 1);
        tick(1);
        chk("rejA_resp_drop", resp_valid, 0);
        chk("rejA_ready", cfg_ready, 1);

        // ---- Rejection B: odiv1=0 ----
        cfg_defaults();
        cfg_odiv1 = 10'd0;
        handshake();
        tick(1);
        chk("rejB_resp_valid", resp_valid, 1);
        chk("rejB_code", resp_code, 1);
        chk("rejB_pll_rst", pll_rst, 0);
        chk("rejB_dyn_odiv1", dyn_odiv1, 200);
        tick(1);

        // ---- Rejection C: phase2=800, odiv2=100 (8*odiv boundary) ----
        cfg_defaults();
        cfg_phase2 = 13'd800;
        handshake();
        tick(1);
        chk("rejC_resp_valid", resp_valid, 1);
        chk("rejC_code", resp_code, 1);
        chk("rejC_pll_rst", pll_rst, 0);
        chk("rejC_dyn_phase2", dyn_phase2, 16);
        tick(1);

        // ---- Glitchy lock with just-in-range request (duty0=199, phase2=799) ----
        cfg_defaults();
        cfg_duty0  = 10'd199;
        cfg_phase2 = 13'd799;
        handshake();                      // edge T
        tick(1);                          // T+1
        chk("gl_dyn_duty0", dyn_duty0, 199);
        chk("gl_dyn_phase2", dyn_phase2, 799);
        chk("gl_dyn_odiv0", dyn_odiv0, 100);
        chk("gl_pll_rst", pll_rst, 1);
        pll_lock = 1'b0;
        tick(16);                         // T+17
        chk("gl_pll_rst_fall", pll_rst, 0);
        pll_lock = 1'b1;                  // 40 high samples
        tick(40);                         // T+57
        pll_lock = 1'b0;                  // one low sample
        tick(1);                          // T+58
        pll_lock = 1'b1;
        tick(24);                         // T+82: unglitched timing would respond here
        chk("gl_no_resp_at_82", resp_valid, 0);
        chk("gl_not_locked_at_82", locked, 0);
        tick(40);                         // T+122
        chk("gl_no_resp_at_122", resp_valid, 0);
        tick(1);                          // T+123
        chk("gl_resp_valid", resp_valid, 1);
        chk("gl_resp_code", resp_code, 0);
        chk("gl_locked", locked, 1);
        tick(1);
        chk("gl_ready", cfg_ready, 1);

        // ---- Lock loss in IDLE ----
        pll_lock = 1'b0;
        tick(1);
        chk("ll_pulse", lock_lost, 1);
        chk("ll_locked_clr", locked, 0);
        pll_lock = 1'b1;
        tick(1);
        chk("ll_pulse_end", lock_lost, 0);
        chk("ll_no_retry_locked", locked, 0);
        chk("ll_no_retry_rst", pll_rst, 0);

        // ---- Lock timeout (pll_lock held low) ----
        pll_lock = 1'b0;
        cfg_defaults();
        cfg_odiv0 = 10'd150;
        handshake();                      // edge T
        tick(1);                          // T+1
        chk("to_dyn_odiv0", dyn_odiv0, 150);
        tick(215);                        // T+216: 199th WAIT_LOCK cycle
        chk("to_no_resp_early", resp_valid, 0);
        tick(1);                          // T+217
        chk("to_resp_valid", resp_valid, 1);
        chk("to_resp_code", resp_code, 2);
        chk("to_locked", locked, 0);
        chk("to_dyn_kept", dyn_odiv0, 150);
        tick(1);
        chk("to_ready", cfg_ready, 1);
        chk("to_resp_drop", resp_valid, 0);

        // ---- Reset in the middle of a request ----
        cfg_defaults();
        cfg_odiv0 = 10'd120;
        handshake();
        tick(1);
        chk("mr_dyn_odiv0", dyn_odiv0, 120);
        tick(5);                          // inside APPLY_RST
        rst_n = 1'b0;
        tick(1);
        chk_reset_state("mr");
        rst_n = 1'b1;                     // new E0
        tick(15);
        chk("mr_boot_rst_hi", pll_rst, 1);
        tick(1);
        chk("mr_boot_rst_fall", pll_rst, 0);
        chk("mr_boot_not_ready", cfg_ready, 0);
        pll_lock = 1'b1;
        tick(64);
        chk("mr_not_locked_yet", locked, 0);
        chk("mr_no_resp", resp_valid, 0);
        tick(1);
        chk("mr_locked", locked, 1);
        chk("mr_ready", cfg_ready, 1);
        chk("mr_boot_no_resp", resp_valid, 0);
        chk("mr_resp_code", resp_code, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
